irq_prio_ctrl: RTL and testbench

Prioritised interrupt controller placed in front of the RISC5 CPU's single edge-triggered irq input. It collects up to NUM_IRQ external request lines, edge-detects them, and latches them as pending. It selects the highest-priority enabled pending source and presents it to the CPU as a one-cycle irq pulse. It tracks the CPU's intAck/RTI/intabort handshake so the handler can read which source is in service. Software configures and inspects it through a small memory-mapped IO register window.

---
 rtl/irq_prio_ctrl.sv | 137 +++++++++++++
 tb/tb_irq_prio_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// Prioritised, edge-triggered interrupt controller in front of the CPU irq pin.
// Optional software trigger register: define IRQ_PRIO_SWTRIG_EN.
module irq_prio_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int NUM_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               wr,
    input  logic [1:0]         addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_ack,
    input  logic               rti,
    input  logic               int_abort,
    output logic               irq_out,
    output logic [NUM_W-1:0]   cur_num,
    output logic               active
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        SERVICE  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [NUM_IRQ-1:0] enable, pend, irq_d;
    logic [NUM_IRQ-1:0] rise, pend_set, pend_clr, pend_nx;
    logic [NUM_W-1:0]   sel, sel_nx, cur_nx, cand;
    logic               cand_vld, irq_nx, act_nx, ack_take;
    logic               wr_en, wr_pend;
    logic               unused_ok;

    assign wr_en   = en & wr & (addr == 2'd0);
    assign wr_pend = en & wr & (addr == 2'd1);
    assign rise    = irq_in & ~irq_d;

`ifdef IRQ_PRIO_SWTRIG_EN
    logic wr_trig;
    assign wr_trig  = en & wr & (addr == 2'd2);
    assign pend_set = rise | (wr_trig ? data_in[NUM_IRQ-1:0] : '0);
`else
    assign pend_set = rise;
`endif

    assign unused_ok = &{1'b0, data_in};

    // Lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i] && enable[i]) begin
                cand     = NUM_W'(i);
                cand_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            enable  <= '0;
            pend    <= '0;
            irq_d   <= '0;
            irq_out <= 1'b0;
            active  <= 1'b0;
            cur_num <= '0;
            sel     <= '0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            irq_d   <= irq_in;
            irq_out <= irq_nx;
            active  <= act_nx;
            cur_num <= cur_nx;
            sel     <= sel_nx;
            if (wr_en) begin
                enable <= data_in[NUM_IRQ-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cand_vld && !active) state_nx = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (int_ack) state_nx = SERVICE;
            end
            SERVICE: begin
                if (rti || int_abort) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Committed sel is cleared from pend on ack; a same-cycle rise still wins.
    always_comb begin
        ack_take = (state == WAIT_ACK) && int_ack;
        irq_nx   = (state == IDLE) && cand_vld && !active;
        sel_nx   = irq_nx ? cand : sel;
        cur_nx   = ack_take ? sel : cur_num;
        act_nx   = active;
        if (ack_take) begin
            act_nx = 1'b1;
        end else if ((state == SERVICE) && (rti || int_abort)) begin
            act_nx = 1'b0;
        end
        pend_clr = '0;
        if (wr_pend) pend_clr = data_in[NUM_IRQ-1:0];
        if (ack_take) pend_clr = pend_clr | (NUM_IRQ'(1) << sel);
        pend_nx = (pend & ~pend_clr) | pend_set;
    end

    always_comb begin
        data_out = '0;
        unique case (addr)
            2'd0: data_out[NUM_IRQ-1:0] = enable;
            2'd1: data_out[NUM_IRQ-1:0] = pend;
            2'd2: data_out = '0;
            2'd3: begin
                data_out[31]        = active;
                data_out[30]        = (state == WAIT_ACK);
                data_out[NUM_W-1:0] = cur_num;
            end
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_irq_prio_ctrl;

    localparam int N = 8;
    localparam int W = 3;
    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_SERV = 2;

    logic          clk = 1'b0;
    logic          rst, en, wr;
    logic [1:0]    addr;
    logic [31:0]   data_in, data_out;
    logic [N-1:0]  irq_in;
    logic          int_ack, rti, int_abort;
    logic          irq_out, active;
    logic [W-1:0]  cur_num;

    always #5 clk = ~clk;

    irq_prio_ctrl #(.NUM_IRQ(N), .NUM_W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .irq_in(irq_in),
        .int_ack(int_ack), .rti(rti), .int_abort(int_abort),
        .irq_out(irq_out), .cur_num(cur_num), .active(active)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state (values visible after the last clock edge).
    int m_en = 0, m_pend = 0, m_irq_d = 0, m_sel = 0, m_cur = 0;
    int m_phase = P_IDLE;
    bit m_irq = 0, m_act = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int lowest(input int v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0: return m_en;
            2'd1: return m_pend;
            2'd2: return 0;
            default: return (m_act ? 32'h8000_0000 : 32'h0)
                          | (m_phase == P_WAIT ? 32'h4000_0000 : 32'h0)
                          | m_cur;
        endcase
    endfunction

    task automatic step(input bit r, input bit e, input bit w,
                        input logic [1:0] a, input logic [31:0] d,
                        input logic [N-1:0] irq,
                        input bit ak, input bit rt, input bit ab);
        int rise, c, np;
        @(negedge clk);
        check("irq_out", irq_out, m_irq);
        check("active", active, m_act);
        check("cur_num", cur_num, m_cur);
        check("data_out", data_out, exp_rd(addr));
        rst = r; en = e; wr = w; addr = a; data_in = d;
        irq_in = irq; int_ack = ak; rti = rt; int_abort = ab;
        if (!r) begin
            m_en = 0; m_pend = 0; m_irq_d = 0; m_irq = 0;
            m_act = 0; m_cur = 0; m_sel = 0; m_phase = P_IDLE;
        end else begin
            rise = int'(irq) & ~m_irq_d;
            c = lowest(m_pend & m_en);
            np = m_pend;
            if (e && w && a == 2'd1) np = np & ~int'(d[N-1:0]);
            if (m_phase == P_WAIT && ak) np = np & ~(1 << m_sel);
            np = np | rise;
`ifdef IRQ_PRIO_SWTRIG_EN
            if (e && w && a == 2'd2) np = np | int'(d[N-1:0]);
`endif
            if (e && w && a == 2'd0) m_en = int'(d[N-1:0]);
            m_irq = 0;
            case (m_phase)
                P_IDLE: if (c >= 0) begin
                    m_sel = c; m_irq = 1; m_phase = P_WAIT;
                end
                P_WAIT: if (ak) begin
                    m_cur = m_sel; m_act = 1; m_phase = P_SERV;
                end
                default: if (rt || ab) begin
                    m_act = 0; m_phase = P_IDLE;
                end
            endcase
            m_pend = np;
            m_irq_d = int'(irq);
        end
    endtask

    task automatic nop(input logic [N-1:0] irq, input logic [1:0] a);
        step(1, 0, 0, a, 0, irq, 0, 0, 0);
    endtask

    initial begin
        logic [N-1:0] irq;
        bit ak, rt;
        rst = 0; en = 0; wr = 0; addr = 0; data_in = 0;
        irq_in = 0; int_ack = 0; rti = 0; int_abort = 0;
        repeat (2) @(posedge clk);

        // Single source 5, full handshake.
        step(1, 1, 1, 0, 32'hFF, 0, 0, 0, 0);
        nop(8'h20, 1);
        nop(8'h20, 3);
        nop(8'h20, 3);
        #1 check("pulse5", irq_out, 1);
        check("st_wait", data_out, 32'h4000_0000);
        step(1, 0, 0, 3, 0, 8'h20, 1, 0, 0);
        nop(0, 3);
        #1 check("st_svc5", data_out, 32'h8000_0005);
        nop(0, 1);
        #1 check("pend_clr", data_out, 0);
        step(1, 0, 0, 3, 0, 0, 0, 1, 0);

        // Sources 6 and 2 together: 2 first, then 6 after a low cycle.
        nop(8'h44, 1);
        nop(8'h44, 1);
        nop(8'h44, 3);
        step(1, 0, 0, 3, 0, 8'h44, 1, 0, 0);
        nop(8'h44, 3);
        #1 check("cur2", cur_num, 2);
        step(1, 0, 0, 3, 0, 8'h44, 0, 1, 0);
        nop(8'h44, 3);
        #1 check("low_gap", irq_out, 0);
        nop(8'h44, 3);
        #1 check("redeliver", irq_out, 1);
        step(1, 0, 0, 3, 0, 0, 1, 0, 0);
        nop(0, 3);
        #1 check("cur6", cur_num, 6);
        step(1, 0, 0, 3, 0, 0, 0, 0, 1);

        // Disabled source stays pending; software clear drops it.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        nop(8'h08, 1);
        nop(8'h08, 1);
        nop(8'h08, 1);
        #1 check("pend3", data_out, 32'h08);
        check("no_irq", irq_out, 0);
        step(1, 1, 1, 1, 32'h08, 8'h08, 0, 0, 0);
        step(1, 1, 1, 0, 32'h08, 8'h08, 0, 0, 0);
        nop(8'h08, 1);
        nop(8'h08, 1);
        #1 check("cleared", data_out, 0);
        check("no_irq2", irq_out, 0);

        // Software trigger of source 7.
        step(1, 1, 1, 2, 32'h80, 8'h08, 0, 0, 0);
        step(1, 1, 1, 0, 32'h80, 8'h08, 0, 0, 0);
        nop(8'h08, 1);
`ifdef IRQ_PRIO_SWTRIG_EN
        #1 check("swtrig", data_out, 32'h80);
`else
        #1 check("swtrig", data_out, 0);
`endif
        nop(8'h08, 2);
        #1 check("rd_trig", data_out, 0);

        // Random traffic against the model.
        irq = 8'h08;
        for (int k = 0; k < 3000; k++) begin
            irq = irq ^ N'($urandom & $urandom & $urandom);
            ak = (m_phase == P_WAIT) ? ($urandom % 3 == 0)
                                     : ($urandom % 25 == 0);
            rt = (m_phase == P_SERV) ? ($urandom % 4 == 0)
                                     : ($urandom % 25 == 0);
            step($urandom_range(0, 299) != 0, $urandom % 3 == 0,
                 $urandom % 2 == 0, 2'($urandom), $urandom, irq,
                 ak, rt, $urandom % 30 == 0);
        end
        nop(irq, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
